// File: rtl/mine_neighbor_counter_pkg.sv
// rtl/mine_neighbor_counter_pkg.sv - shared types, widths and neighbour offsets for the board sequencers
// Purpose: one-hot FSM state encoding, count width, coordinate width helper and the
//          8-entry neighbour offset table (dx/dy indexed by k).
// Ports:   none (package).
package minesweeper_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [3:0] {
    ST_INIT  = 4'b0001,
    ST_SCAN  = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  // Width of a coordinate that indexes 0..n-1; never narrower than one bit.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Offsets are 2-bit two's complement: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
  // k order: (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
  function automatic logic [1:0] dx_of(input logic [2:0] k);
    case (k)
      3'd0, 3'd3, 3'd5: dx_of = 2'b11;
      3'd1, 3'd6:       dx_of = 2'b00;
      default:          dx_of = 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] dy_of(input logic [2:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: dy_of = 2'b11;
      3'd3, 3'd4:       dy_of = 2'b00;
      default:          dy_of = 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/mine_neighbor_counter_if.sv
// rtl/mine_neighbor_counter_if.sv - handshake and board-access bundle of the neighbour counter
// Purpose: groups start/ack/done, the mine-board read port and the count-board write port.
// Ports:   master = controller/board side (drives start, ack, mineBoardReadValue);
//          slave  = mine_neighbor_counter (drives read/write addresses, count, strobes, done).
interface mine_neighbor_counter_if #(
  parameter int XW = 3,
  parameter int YW = 3
);
  import minesweeper_pkg::*;

  logic               start;
  logic               ack;
  logic [XW-1:0]      readX;
  logic [YW-1:0]      readY;
  logic               mineBoardReadValue;
  logic [XW-1:0]      writeX;
  logic [YW-1:0]      writeY;
  logic [COUNT_W-1:0] countOut;
  logic               writeCountEn;
  logic               done;

  modport master (
    output start, ack, mineBoardReadValue,
    input  readX, readY, writeX, writeY, countOut, writeCountEn, done
  );

  modport slave (
    input  start, ack, mineBoardReadValue,
    output readX, readY, writeX, writeY, countOut, writeCountEn, done
  );

endinterface

// File: rtl/mine_neighbor_counter_neighbor_addr.sv
// rtl/mine_neighbor_counter_neighbor_addr.sv - neighbour address generator with bounds check
// Purpose: combinational (cell_x, cell_y, k) -> (read_x, read_y, in_bounds).
// Ports:   cell_x/cell_y  current cell; k  neighbour index 0..7;
//          read_x/read_y  low bits of neighbour coordinate; in_bounds  neighbour lies on the board.
module neighbor_addr
  import minesweeper_pkg::*;
#(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8,
  localparam int XW = coord_w(boardWidth),
  localparam int YW = coord_w(boardHeight)
) (
  input  logic [XW-1:0] cell_x,
  input  logic [YW-1:0] cell_y,
  input  logic [2:0]    k,
  output logic [XW-1:0] read_x,
  output logic [YW-1:0] read_y,
  output logic          in_bounds
);

  localparam logic [XW:0] X_LIM = (XW+1)'(boardWidth);
  localparam logic [YW:0] Y_LIM = (YW+1)'(boardHeight);

  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic        [XW:0] nx;
  logic        [YW:0] ny;

  // One extra sign bit: -1 shows up with the top bit set, as does an overflow past the
  // last column on power-of-two boards, so both fall out of bounds.
  always_comb begin
    dx = dx_of(k);
    dy = dy_of(k);
    nx = $signed({1'b0, cell_x}) + dx;
    ny = $signed({1'b0, cell_y}) + dy;
    in_bounds = !nx[XW] && (nx < X_LIM) && !ny[YW] && (ny < Y_LIM);
    read_x = nx[XW-1:0];
    read_y = ny[YW-1:0];
  end

endmodule

// File: rtl/mine_neighbor_counter.sv
// rtl/mine_neighbor_counter.sv - counts adjacent mines for every cell of the board
// Purpose: scans cells row-major, reads 8 neighbours per cell (8 cycles), then writes the
//          count (1 cycle); start/done/ack handshake like the other board sequencers.
// Ports:   clk, reset (sync, active-low); bus (slave): start, ack, readX/readY,
//          mineBoardReadValue, writeX/writeY, countOut, writeCountEn, done.
module mine_neighbor_counter
  import minesweeper_pkg::*;
#(
  parameter int boardWidth  = 8,
  parameter int boardHeight = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mine_neighbor_counter_if.slave bus
);

  localparam int XW = coord_w(boardWidth);
  localparam int YW = coord_w(boardHeight);
  localparam logic [XW-1:0] X_LAST = XW'(boardWidth - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(boardHeight - 1);

  state_t             state;
  logic [XW-1:0]      cell_x;
  logic [YW-1:0]      cell_y;
  logic [2:0]         k;
  logic [COUNT_W-1:0] sum;

  logic [XW-1:0]      addr_x;
  logic [YW-1:0]      addr_y;
  logic               in_bounds;

  neighbor_addr #(
    .boardWidth (boardWidth),
    .boardHeight(boardHeight)
  ) u_neighbor_addr (
    .cell_x   (cell_x),
    .cell_y   (cell_y),
    .k        (k),
    .read_x   (addr_x),
    .read_y   (addr_y),
    .in_bounds(in_bounds)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_INIT;
      cell_x <= '0;
      cell_y <= '0;
      k      <= '0;
      sum    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cell_x <= '0;
          cell_y <= '0;
          k      <= '0;
          sum    <= '0;
          if (bus.start) state <= ST_SCAN;
        end
        ST_SCAN: begin
          sum <= sum + COUNT_W'(in_bounds & bus.mineBoardReadValue);
          if (k == 3'd7) state <= ST_WRITE;
          else           k <= k + 3'd1;
        end
        ST_WRITE: begin
          k   <= '0;
          sum <= '0;
          if (cell_x == X_LAST && cell_y == Y_LAST) begin
            state <= ST_DONE;
          end else begin
            state <= ST_SCAN;
            if (cell_x == X_LAST) begin
              cell_x <= '0;
              cell_y <= cell_y + YW'(1);
            end else begin
              cell_x <= cell_x + XW'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.ack) state <= ST_INIT;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Outside SCAN the read address parks on the current cell, so it reads 0 after reset.
  assign bus.readX        = (state == ST_SCAN) ? addr_x : cell_x;
  assign bus.readY        = (state == ST_SCAN) ? addr_y : cell_y;
  assign bus.writeX       = cell_x;
  assign bus.writeY       = cell_y;
  assign bus.countOut     = sum;
  assign bus.writeCountEn = (state == ST_WRITE);
  assign bus.done         = (state == ST_DONE);

endmodule

// File: tb/tb_mine_neighbor_counter.sv
// tb/tb_mine_neighbor_counter.sv - scoreboard bench for mine_neighbor_counter
module tb_mine_neighbor_counter;
  import minesweeper_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mine_neighbor_counter_if #(.XW(3), .YW(3)) bus();

  mine_neighbor_counter #(.boardWidth(W), .boardHeight(H)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic mine [H][W];
  assign bus.mineBoardReadValue = mine[bus.readY][bus.readX];

  typedef struct {int x; int y; int c;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_pulse = 0;
  bit first_pulse = 1'b1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.writeCountEn) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write x=%0d y=%0d count=%0d (no write expected)",
                 bus.writeX, bus.writeY, bus.countOut);
      end else begin
        e = sb.pop_front();
        if (int'(bus.writeX) != e.x || int'(bus.writeY) != e.y || int'(bus.countOut) != e.c) begin
          bad++;
          $display("FAIL cell_write got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                   bus.writeX, bus.writeY, bus.countOut, e.x, e.y, e.c);
        end
      end
      if (!first_pulse) begin
        total++;
        if (cyc - last_pulse != 9) begin
          bad++;
          $display("FAIL pulse_spacing got %0d expected 9", cyc - last_pulse);
        end
      end
      first_pulse = 1'b0;
      last_pulse = cyc;
    end
  end

  function automatic int ref_count(int x, int y);
    int n = 0;
    for (int oy = -1; oy <= 1; oy++)
      for (int ox = -1; ox <= 1; ox++)
        if (!(ox == 0 && oy == 0) && x + ox >= 0 && x + ox < W && y + oy >= 0 && y + oy < H)
          n += mine[y + oy][x + ox] ? 1 : 0;
    return n;
  endfunction

  task automatic load_expect();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back('{x, y, ref_count(x, y)});
    first_pulse = 1'b1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_board();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mine[y][x] = 1'b0;
  endtask

  task automatic random_board(input int density);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mine[y][x] = ($urandom_range(0, 99) < density);
  endtask

  // Inputs change #1 after a rising edge; done is observed at the same point.
  task automatic run_scan(input bit mid_pulse, input bit ack_with_start);
    int n;
    int held;
    load_expect();
    bus.start = 1'b1;
    bus.ack = ack_with_start;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ack = 1'b0;
    n = 0;
    while (!bus.done && n < 1000) begin
      bus.start = (mid_pulse && n == 50);
      bus.ack = (mid_pulse && n == 50);
      @(posedge clk);
      n++;
      #1;
    end
    bus.start = 1'b0;
    bus.ack = 1'b0;
    check("done_latency", n, 576);
    check("all_cells_written", sb.size(), 0);
    sb.delete();
    held = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) held++;
    end
    check("done_hold", held, 20);
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    check("done_after_ack", int'(bus.done), 0);
    check("idle_no_write", int'(bus.writeCountEn), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.ack = 1'b0;
    clear_board();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_writeCountEn", int'(bus.writeCountEn), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_countOut", int'(bus.countOut), 0);
    check("reset_writeX", int'(bus.writeX), 0);
    check("reset_writeY", int'(bus.writeY), 0);
    check("reset_readX", int'(bus.readX), 0);
    check("reset_readY", int'(bus.readY), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    clear_board();
    run_scan(1'b0, 1'b0);

    clear_board();
    mine[4][3] = 1'b1;
    run_scan(1'b0, 1'b0);

    clear_board();
    mine[0][0] = 1'b1;
    run_scan(1'b0, 1'b1);

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mine[y][x] = 1'b1;
    run_scan(1'b0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      random_board($urandom_range(10, 60));
      run_scan(t == 1, 1'b0);
    end

    // Abort mid-scan, then rescan the same board from scratch.
    random_board(35);
    load_expect();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("abort_writeCountEn", int'(bus.writeCountEn), 0);
    check("abort_done", int'(bus.done), 0);
    sb.delete();
    repeat (12) @(posedge clk);
    #1;
    check("abort_idle_done", int'(bus.done), 0);
    check("abort_idle_write", int'(bus.writeCountEn), 0);
    run_scan(1'b0, 1'b0);
    run_scan(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
